// File: rtl/task_stream_manager.sv
// Manager endpoint of the byte-stream task interface. It streams a buffered request to a task core,
// then collects the answer stream and reports its byte count, last byte and error status.
module task_stream_manager #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_start,
    input  logic [11:0]       i_len,
    output logic [7:0]        o_tdata,
    output logic              o_tdata_valid,
    output logic              o_tdata_last,
    input  logic              i_tready,
    output logic              o_tmanager_ready,
    input  logic              i_tanswer_ready,
    input  logic [7:0]        i_tanswer_data,
    input  logic              i_tanswer_data_last,
    input  logic [11:0]       i_packet_size_in_bytes,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err,
    output logic [11:0]       o_ans_count,
    output logic [7:0]        o_ans_last_byte
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [11:0]     len_q;
    logic [11:0]     sent_cnt;
    logic [TW-1:0]   timer;
    logic [11:0]     ans_cnt_nx;
    logic            start_acc, send_fire, last_send, ans_fire, timeout_hit;

    assign start_acc   = (state == S_IDLE) && i_start;
    assign send_fire   = (state == S_SEND) && i_tready;
    assign last_send   = (sent_cnt == len_q - 12'd1);
    assign ans_fire    = (state == S_WAIT) && i_tanswer_ready;
    assign timeout_hit = (state == S_WAIT) && !i_tanswer_ready && (timer == TW'(TIMEOUT - 1));
    assign ans_cnt_nx  = (o_ans_count == 12'hFFF) ? o_ans_count : o_ans_count + 12'd1;

    // The buffer is plain storage: no reset, writable only while no request is in flight.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (state == S_IDLE || state == S_DONE))
            mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        o_tdata_valid    = 1'b0;
        o_tdata          = 8'h00;
        o_tdata_last     = 1'b0;
        o_tmanager_ready = 1'b0;
        o_busy           = 1'b0;
        o_done           = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) state_nx = (i_len == 12'd0) ? S_DONE : S_SEND;
            end
            S_SEND: begin
                o_busy        = 1'b1;
                o_tdata_valid = 1'b1;
                // Read index wraps with the buffer when len exceeds DEPTH.
                o_tdata       = mem[sent_cnt[ADDR_W-1:0]];
                o_tdata_last  = last_send;
                if (i_tready && last_send) state_nx = S_WAIT;
            end
            S_WAIT: begin
                o_busy           = 1'b1;
                o_tmanager_ready = 1'b1;
                if ((ans_fire && i_tanswer_data_last) || timeout_hit) state_nx = S_DONE;
            end
            S_DONE: begin
                o_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_q           <= '0;
            sent_cnt        <= '0;
            timer           <= '0;
            o_err           <= 2'd0;
            o_ans_count     <= '0;
            o_ans_last_byte <= '0;
        end else if (start_acc) begin
            len_q       <= i_len;
            sent_cnt    <= '0;
            timer       <= '0;
            o_ans_count <= '0;
            o_err       <= (i_len == 12'd0) ? 2'd3 : 2'd0;
        end else if (send_fire) begin
            sent_cnt <= sent_cnt + 12'd1;
        end else if (state == S_WAIT) begin
            if (ans_fire) begin
                o_ans_count     <= ans_cnt_nx;
                o_ans_last_byte <= i_tanswer_data;
                timer           <= '0;
                // Size check counts the beat being accepted now.
                if (i_tanswer_data_last)
                    o_err <= (i_packet_size_in_bytes != ans_cnt_nx) ? 2'd2 : 2'd0;
            end else if (timeout_hit) begin
                o_err <= 2'd1;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_task_stream_manager.sv
// Randomized bench for task_stream_manager: a transaction-level model predicts request bytes,
// answer bookkeeping, timeouts and error codes.
module tb_task_stream_manager;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_wr_en = 1'b0;
    logic [ADDR_W-1:0] i_wr_addr = '0;
    logic [7:0]        i_wr_data = '0;
    logic              i_start = 1'b0;
    logic [11:0]       i_len = '0;
    logic [7:0]        o_tdata;
    logic              o_tdata_valid, o_tdata_last;
    logic              i_tready = 1'b0;
    logic              o_tmanager_ready;
    logic              i_tanswer_ready = 1'b0;
    logic [7:0]        i_tanswer_data = '0;
    logic              i_tanswer_data_last = 1'b0;
    logic [11:0]       i_packet_size_in_bytes = '0;
    logic              o_busy, o_done;
    logic [1:0]        o_err;
    logic [11:0]       o_ans_count;
    logic [7:0]        o_ans_last_byte;

    always #5 clk = ~clk;

    task_stream_manager #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .i_len(i_len),
        .o_tdata(o_tdata), .o_tdata_valid(o_tdata_valid), .o_tdata_last(o_tdata_last),
        .i_tready(i_tready), .o_tmanager_ready(o_tmanager_ready),
        .i_tanswer_ready(i_tanswer_ready), .i_tanswer_data(i_tanswer_data),
        .i_tanswer_data_last(i_tanswer_data_last), .i_packet_size_in_bytes(i_packet_size_in_bytes),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_ans_count(o_ans_count), .o_ans_last_byte(o_ans_last_byte)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_m [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs that must have no effect outside IDLE/DONE.
    task automatic junk();
        i_start   = ($urandom_range(0, 3) == 0);
        i_len     = 12'($urandom);
        i_wr_en   = ($urandom_range(0, 1) == 1);
        i_wr_addr = ADDR_W'($urandom);
        i_wr_data = 8'($urandom);
    endtask

    task automatic quiet();
        i_start = 1'b0; i_wr_en = 1'b0; i_tready = 1'b0;
        i_tanswer_ready = 1'b0; i_tanswer_data_last = 1'b0;
    endtask

    task automatic host_wr(input int addr, input logic [7:0] data);
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_addr = ADDR_W'(addr); i_wr_data = data;
        mem_m[addr % DEPTH] = data;
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    // One full transaction. nb answer beats (ignored when no_ans) with reported size 'size'.
    task automatic txn(input int len, input int rdy_pct, input int nb, input int size, input bit no_ans);
        int idx, cyc, g;
        logic [7:0] lb;
        logic [1:0] exp_err;
        bit chk_cnt;
        lb = 8'h00; chk_cnt = 1'b1;
        @(negedge clk);
        quiet();
        i_start = 1'b1; i_len = 12'(len);
        if (len == 0) begin
            exp_err = 2'd3; chk_cnt = 1'b0;
            @(negedge clk);
            quiet();
        end else begin
            idx = 0; cyc = 0;
            while (idx < len && cyc < 2000) begin
                @(negedge clk);
                chk("send_valid", o_tdata_valid, 1);
                chk("send_data",  o_tdata, mem_m[idx % DEPTH]);
                chk("send_last",  o_tdata_last, (idx == len - 1));
                chk("send_mrdy",  o_tmanager_ready, 0);
                chk("send_busy",  o_busy, 1);
                junk();
                i_tanswer_ready = ($urandom_range(0, 1) == 1);
                i_tanswer_data_last = 1'b1;
                i_tready = ($urandom_range(1, 100) <= rdy_pct);
                if (i_tready) idx++;
                cyc++;
            end
            chk("send_bound", (cyc < 2000), 1);
            if (no_ans) begin
                exp_err = 2'd1;
                g = 0;
                forever begin
                    @(negedge clk);
                    quiet(); junk();
                    if (o_done || g > TIMEOUT + 4) break;
                    chk("to_mrdy", o_tmanager_ready, 1);
                    g++;
                end
                quiet();
                chk("to_cycles", g, TIMEOUT);
            end else begin
                for (int b = 0; b < nb; b++) begin
                    // Occasional gap of TIMEOUT-1 idle cycles: the longest that must not abort.
                    g = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
                    for (int k = 0; k < g; k++) begin
                        @(negedge clk);
                        quiet(); junk();
                        i_tanswer_data = 8'($urandom);
                        chk("gap_mrdy", o_tmanager_ready, 1);
                        chk("gap_done", o_done, 0);
                    end
                    @(negedge clk);
                    quiet();
                    chk("beat_mrdy", o_tmanager_ready, 1);
                    chk("beat_cnt", o_ans_count, b);
                    i_tanswer_ready = 1'b1;
                    i_tanswer_data = 8'($urandom);
                    i_tanswer_data_last = (b == nb - 1);
                    i_packet_size_in_bytes = 12'(size);
                    lb = i_tanswer_data;
                end
                @(negedge clk);
                quiet();
                exp_err = (size != nb) ? 2'd2 : 2'd0;
            end
        end
        chk("done_pulse", o_done, 1);
        chk("done_busy", o_busy, 0);
        chk("done_err", o_err, exp_err);
        if (chk_cnt && !no_ans) begin
            chk("done_cnt", o_ans_count, nb);
            chk("done_lastbyte", o_ans_last_byte, lb);
        end else if (chk_cnt) begin
            chk("done_cnt", o_ans_count, 0);
        end
        // Start in DONE is ignored; a host write in DONE lands.
        i_start = 1'b1; i_len = 12'd5;
        i_wr_en = 1'b1; i_wr_addr = ADDR_W'($urandom); i_wr_data = 8'($urandom);
        mem_m[i_wr_addr] = i_wr_data;
        @(negedge clk);
        quiet();
        chk("post_done", o_done, 0);
        chk("post_busy", o_busy, 0);
        chk("post_err", o_err, exp_err);
    endtask

    initial begin
        #1;
        chk("rst_valid", o_tdata_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_cnt", o_ans_count, 0);
        chk("rst_lb", o_ans_last_byte, 0);
        chk("rst_mrdy", o_tmanager_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) host_wr(a, 8'($urandom));

        host_wr(0, 8'h11); host_wr(1, 8'h22); host_wr(2, 8'h33);
        txn(3, 100, 1, 1, 1'b0);
        txn(3, 50, 1, 1, 1'b0);
        txn(3, 100, 2, 3, 1'b0);
        txn(4, 100, 0, 0, 1'b1);
        txn(0, 100, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int len, nb, sz;
            repeat ($urandom_range(0, 3)) host_wr($urandom_range(0, DEPTH - 1), 8'($urandom));
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            nb  = $urandom_range(1, 6);
            sz  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : nb;
            txn(len, $urandom_range(20, 100), nb, sz, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        quiet();
        i_start = 1'b1; i_len = 12'd10; i_tready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        chk("mid_valid_pre", o_tdata_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", o_tdata_valid, 0);
        chk("mid_last", o_tdata_last, 0);
        chk("mid_busy", o_busy, 0);
        @(negedge clk);
        rst = 1'b0; quiet();
        @(negedge clk);
        chk("mid_idle_busy", o_busy, 0);
        chk("mid_idle_valid", o_tdata_valid, 0);
        chk("mid_idle_cnt", o_ans_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
